// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: stall/redirect inputs from the pipeline, IF->ID bus and instruction SRAM request.
// The master side is the fetch stage, which drives the SRAM request and the IF->ID bus.
interface if_fetch_stage_if;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        if_adel;

    modport master (
        input  stall,
        input  br_bus,
        output if_to_id_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        output if_adel
    );

    modport slave (
        output stall,
        output br_bus,
        input  if_to_id_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  if_adel
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, one-entry pending-redirect buffer, instruction SRAM request.
// Define IF_ADEL_CHECK_EN to flag misaligned fetches and suppress their SRAM access.
module if_fetch_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    if_fetch_stage_if.master       bus
);

    typedef enum logic [1:0] {S_RESET, S_FETCH, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ce_q, ce_d;
    logic            pend_valid_q, pend_valid_d;
    logic [PC_W-1:0] pend_addr_q, pend_addr_d;

    logic            br_e;
    logic [PC_W-1:0] br_addr;
    logic            stall_pc;
    logic [PC_W-1:0] next_pc;
    logic            adel;

    // Only stall[0] matters here; the IF->ID bus is driven straight from pc_q/ce_q, which already freeze with it.
    logic unused_stall;
    assign unused_stall = ^bus.stall[5:1];

    assign br_e     = bus.br_bus[32];
    assign br_addr  = bus.br_bus[31:0];
    assign stall_pc = bus.stall[0];

    // A live redirect beats a buffered one; the PC increment wraps naturally at 2^32.
    assign next_pc = br_e         ? br_addr :
                     pend_valid_q ? pend_addr_q :
                                    pc_q + PC_W'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ce_d         = ce_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        case (state_q)
            S_RESET: begin
                if (!stall_pc) begin
                    pc_d    = next_pc;
                    ce_d    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!stall_pc) begin
                    pc_d = next_pc;
                    ce_d = 1'b1;
                end else begin
                    state_d = S_HOLD;
                    if (br_e) begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = br_addr;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_pc) begin
                    pc_d         = next_pc;
                    ce_d         = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end else if (br_e) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = br_addr;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC - PC_W'(4);
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

`ifdef IF_ADEL_CHECK_EN
    assign adel = ce_q & (pc_q[1:0] != 2'b00);
`else
    assign adel = 1'b0;
`endif

    assign bus.if_to_id_bus    = {ce_q, pc_q};
    assign bus.inst_sram_en    = ce_q & ~adel;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_q;
    assign bus.inst_sram_wdata = 32'h0;
    assign bus.if_adel         = adel;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: each step queues the expected fetch state and checks it after the edge.
module tb_if_fetch_stage;

    typedef struct packed {
        logic [32:0] id_bus;
        logic        en;
        logic [31:0] addr;
        logic        adel;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } obs_t;

    logic clk;
    logic rst;
    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    obs_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    // Drive one cycle of stimulus, queue the expected post-edge state, then pop and compare.
    task automatic step(input string tag, input logic r, input logic s0,
                        input logic be, input logic [31:0] ba,
                        input logic exp_ce, input logic [31:0] exp_pc);
        obs_t  e;
        obs_t  g;
        string t;
        logic  mis;
        rst       = r;
        bus.stall = {5'b0, s0};
        bus.br_bus = {be, ba};
        mis = (exp_pc[1:0] != 2'b00);
        e.id_bus = {exp_ce, exp_pc};
        e.addr   = exp_pc;
        e.wen    = 4'b0000;
        e.wdata  = 32'h0;
`ifdef IF_ADEL_CHECK_EN
        e.adel   = exp_ce & mis;
        e.en     = exp_ce & ~mis;
`else
        e.adel   = 1'b0;
        e.en     = exp_ce;
`endif
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        g.id_bus = bus.if_to_id_bus;
        g.en     = bus.inst_sram_en;
        g.addr   = bus.inst_sram_addr;
        g.adel   = bus.if_adel;
        g.wen    = bus.inst_sram_wen;
        g.wdata  = bus.inst_sram_wdata;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        $display("step %-10s rst=%b s0=%b br=%b/%h -> ce=%b pc=%h en=%b adel=%b",
                 t, r, s0, be, ba, g.id_bus[32], g.addr, g.en, g.adel);
        assert (g === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, g, e);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.stall  = 6'b0;
        bus.br_bus = 33'b0;

        // T1 reset and sequential fetch
        step("t1_rst0",  1, 0, 0, 32'h0, 0, 32'hBFBF_FFFC);
        step("t1_rst1",  1, 0, 0, 32'h0, 0, 32'hBFBF_FFFC);
        step("t1_f0",    0, 0, 0, 32'h0, 1, 32'hBFC0_0000);
        step("t1_f1",    0, 0, 0, 32'h0, 1, 32'hBFC0_0004);
        step("t1_f2",    0, 0, 0, 32'h0, 1, 32'hBFC0_0008);

        // T2 stall-free redirect, consumed immediately
        step("t2_br",    0, 0, 1, 32'hBFC0_0100, 1, 32'hBFC0_0100);
        step("t2_seq",   0, 0, 0, 32'h0,         1, 32'hBFC0_0104);
        step("t2_to10",  0, 0, 1, 32'hBFC0_0010, 1, 32'hBFC0_0010);

        // T3 redirect captured in the first stall cycle, applied on release
        step("t3_s1",    0, 1, 1, 32'hBFC0_0200, 1, 32'hBFC0_0010);
        step("t3_s2",    0, 1, 0, 32'h0,         1, 32'hBFC0_0010);
        step("t3_s3",    0, 1, 0, 32'h0,         1, 32'hBFC0_0010);
        step("t3_rel",   0, 0, 0, 32'h0,         1, 32'hBFC0_0200);
        step("t3_clr",   0, 0, 0, 32'h0,         1, 32'hBFC0_0204);

        // T4a youngest pending redirect wins
        step("t4_s1",    0, 1, 1, 32'hBFC0_0300, 1, 32'hBFC0_0204);
        step("t4_s2",    0, 1, 1, 32'hBFC0_0400, 1, 32'hBFC0_0204);
        step("t4_rel",   0, 0, 0, 32'h0,         1, 32'hBFC0_0400);
        step("t4_seq",   0, 0, 0, 32'h0,         1, 32'hBFC0_0404);
        // T4b live redirect on the release cycle beats the pending one
        step("t4b_s1",   0, 1, 1, 32'hBFC0_0300, 1, 32'hBFC0_0404);
        step("t4b_s2",   0, 1, 0, 32'h0,         1, 32'hBFC0_0404);
        step("t4b_rel",  0, 0, 1, 32'hBFC0_0500, 1, 32'hBFC0_0500);
        step("t4b_seq",  0, 0, 0, 32'h0,         1, 32'hBFC0_0504);

        // T5 reset mid-stall with a pending redirect, plus a stalled first fetch
        step("t5_s1",    0, 1, 1, 32'hBFC0_0600, 1, 32'hBFC0_0504);
        step("t5_rst",   1, 1, 0, 32'h0,         0, 32'hBFBF_FFFC);
        step("t5_rstst", 0, 1, 0, 32'h0,         0, 32'hBFBF_FFFC);
        step("t5_f0",    0, 0, 0, 32'h0,         1, 32'hBFC0_0000);
        step("t5_f1",    0, 0, 0, 32'h0,         1, 32'hBFC0_0004);

        // PC wrap and a plain stall with no redirect
        step("wrap_br",  0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        step("wrap_0",   0, 0, 0, 32'h0,         1, 32'h0000_0000);
        step("nbr_s1",   0, 1, 0, 32'h0,         1, 32'h0000_0000);
        step("nbr_rel",  0, 0, 0, 32'h0,         1, 32'h0000_0004);

        // T6 misaligned redirect target
        step("t6_br",    0, 0, 1, 32'hBFC0_0102, 1, 32'hBFC0_0102);
        step("t6_seq",   0, 0, 0, 32'h0,         1, 32'hBFC0_0106);
        step("t6_algn",  0, 0, 1, 32'hBFC0_0200, 1, 32'hBFC0_0200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
